// File: rtl/alu_seq_core.sv
// Multi-cycle ALU: one-cycle arithmetic/logic, bit-serial shifts, optional
// shift-add multiply compiled in with ALU_SEQ_MUL_EN.
module alu_seq_core #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             sel_b,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CW = SHW + 1;

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, MUL} state_t;
    localparam logic [CW-1:0] MUL_CYC = CW'(WIDTH);
`else
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] wa_q, wa_d, wb_q, wb_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d, mc_q, mc_d, acc_n;
`endif

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] sh_val;
    logic             sh_out;

    // Single-cycle datapath and one shift step on the working copies
    always_comb begin
        sum  = {1'b0, wa_q} + {1'b0, wb_q};
        diff = {1'b0, wa_q} - {1'b0, wb_q};
        if (op_q == 3'b101) begin
            sh_val = {wa_q[WIDTH-2:0], 1'b0};
            sh_out = wa_q[WIDTH-1];
        end else begin
            sh_val = {1'b0, wa_q[WIDTH-1:1]};
            sh_out = wa_q[0];
        end
`ifdef ALU_SEQ_MUL_EN
        acc_n = acc_q + (wb_q[0] ? mc_q : '0);
`endif
    end

    // Next-state, operand capture and result/flag update
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        wa_d    = wa_q;
        wb_d    = wb_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        acc_d   = acc_q;
        mc_d    = mc_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    if (sel_b) b_d = din;
                    else       a_d = din;
                end
                if (start) begin
                    op_d  = op;
                    wa_d  = a_q;
                    wb_d  = b_q;
                    cnt_d = CW'(shamt);
                    unique case (op)
                        3'b101, 3'b110: state_d = SHIFT;
`ifdef ALU_SEQ_MUL_EN
                        3'b111: begin
                            state_d = MUL;
                            cnt_d   = MUL_CYC;
                            acc_d   = '0;
                            mc_d    = {{WIDTH{1'b0}}, a_q};
                        end
`endif
                        default: state_d = EXEC;
                    endcase
                end
            end
            EXEC: begin
                carry_d = 1'b0;
                ovf_d   = 1'b0;
                unique case (op_q)
                    3'b000: begin
                        y_d     = sum[WIDTH-1:0];
                        carry_d = sum[WIDTH];
                        ovf_d   = (wa_q[WIDTH-1] == wb_q[WIDTH-1]) &&
                                  (sum[WIDTH-1] != wa_q[WIDTH-1]);
                    end
                    3'b001: begin
                        y_d     = diff[WIDTH-1:0];
                        carry_d = ~diff[WIDTH];
                        ovf_d   = (wa_q[WIDTH-1] != wb_q[WIDTH-1]) &&
                                  (diff[WIDTH-1] != wa_q[WIDTH-1]);
                    end
                    3'b010:  y_d = wa_q & wb_q;
                    3'b011:  y_d = wa_q | wb_q;
                    3'b100:  y_d = wa_q ^ wb_q;
                    default: y_d = '0;
                endcase
                done_d  = 1'b1;
                state_d = IDLE;
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    y_d     = wa_q;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CW'(1)) begin
                    y_d     = sh_val;
                    carry_d = sh_out;
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wa_d  = sh_val;
                    cnt_d = cnt_q - CW'(1);
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                acc_d = acc_n;
                mc_d  = {mc_q[2*WIDTH-2:0], 1'b0};
                wb_d  = {1'b0, wb_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    y_d     = acc_n[WIDTH-1:0];
                    carry_d = 1'b0;
                    ovf_d   = |acc_n[2*WIDTH-1:WIDTH];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        zero_d = (y_d == '0);
        busy_d = (state_d != IDLE);
    end

    // State register with synchronous reset overriding load and start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            wa_q    <= '0;
            wb_q    <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q   <= '0;
            mc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q   <= acc_d;
            mc_q    <= mc_d;
`endif
        end
    end

    assign y        = y_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core (WIDTH=8): stimulus pushes expected
// results, a monitor pops and compares on each done pulse.
module tb_alu_seq_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       sel_b = 1'b0;
    logic [7:0] din = '0;
    logic       start = 1'b0;
    logic [2:0] op = '0;
    logic [2:0] shamt = '0;
    logic [7:0] y;
    logic       zero, carry, overflow, busy, done;

    typedef struct {
        int dc;
        int y;
        int z;
        int c;
        int v;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    alu_seq_core #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .load(load), .sel_b(sel_b), .din(din),
        .start(start), .op(op), .shamt(shamt), .y(y), .zero(zero),
        .carry(carry), .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // monitor: compare every done pulse against the head of the queue
    always begin
        @(posedge clk);
        #1;
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.dc);
                chk("y", int'(y), e.y);
                chk("zero", int'(zero), e.z);
                chk("carry", int'(carry), e.c);
                chk("overflow", int'(overflow), e.v);
            end
        end
    end

    task automatic ld(input logic s, input logic [7:0] d);
        load = 1'b1;
        sel_b = s;
        din = d;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_idle(input int lat, input string name);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk(name, n, lat);
    endtask

    task automatic run_op(input logic [2:0] o, input int sh,
                          input int ey, input int ez, input int ec,
                          input int ev, input int lat);
        exp_t e;
        start = 1'b1;
        op = o;
        shamt = 3'(sh);
        @(posedge clk);
        #1;
        start = 1'b0;
        e.dc = cyc + lat;
        e.y = ey;
        e.z = ez;
        e.c = ec;
        e.v = ev;
        q.push_back(e);
        wait_idle(lat, "busy_cycles");
    endtask

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_y", int'(y), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_carry", int'(carry), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);

        ld(1'b0, 8'h7F);
        ld(1'b1, 8'h01);
        run_op(3'b000, 0, 'h80, 0, 0, 1, 1);
        ld(1'b0, 8'h05);
        ld(1'b1, 8'h05);
        run_op(3'b001, 0, 'h00, 1, 1, 0, 1);
        ld(1'b0, 8'h81);
        run_op(3'b101, 3, 'h08, 0, 0, 0, 3);
        ld(1'b0, 8'h10);
        ld(1'b1, 8'h11);
`ifdef ALU_SEQ_MUL_EN
        run_op(3'b111, 0, 'h10, 0, 0, 1, 8);
`else
        run_op(3'b111, 0, 'h00, 1, 0, 0, 1);
`endif
        ld(1'b0, 8'hF0);
        ld(1'b1, 8'h3C);
        run_op(3'b010, 0, 'h30, 0, 0, 0, 1);
        run_op(3'b011, 0, 'hFC, 0, 0, 0, 1);
        run_op(3'b100, 0, 'hCC, 0, 0, 0, 1);
        run_op(3'b110, 0, 'hF0, 0, 0, 0, 1);
        ld(1'b0, 8'hFF);
        ld(1'b1, 8'h01);
        run_op(3'b000, 0, 'h00, 1, 1, 0, 1);
        ld(1'b0, 8'h01);
        ld(1'b1, 8'h02);
        run_op(3'b001, 0, 'hFF, 0, 0, 0, 1);
        ld(1'b0, 8'h80);
        ld(1'b1, 8'h01);
        run_op(3'b001, 0, 'h7F, 0, 1, 1, 1);
        ld(1'b0, 8'hF1);
        run_op(3'b110, 1, 'h78, 0, 1, 0, 1);
        ld(1'b0, 8'h03);
        run_op(3'b101, 7, 'h80, 0, 1, 0, 7);

        // reset in the 2nd SHIFT cycle aborts with no done
        ld(1'b0, 8'hF0);
        start = 1'b1;
        op = 3'b110;
        shamt = 3'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_y", int'(y), 0);
        chk("abort_zero", int'(zero), 1);
        repeat (8) @(posedge clk);
        #1;

        // start and load during SHIFT are ignored
        ld(1'b0, 8'h5A);
        ld(1'b1, 8'h0F);
        start = 1'b1;
        op = 3'b101;
        shamt = 3'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.dc = cyc + 4;
        e.y = 'hA0;
        e.z = 0;
        e.c = 1;
        e.v = 0;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b1;
        op = 3'b000;
        load = 1'b1;
        sel_b = 1'b0;
        din = 8'hAA;
        @(posedge clk);
        #1;
        start = 1'b0;
        load = 1'b0;
        wait_idle(2, "busy_tail");
        repeat (3) @(posedge clk);
        #1;
        run_op(3'b000, 0, 'h69, 0, 0, 0, 1);
        run_op(3'b001, 0, 'h4B, 0, 1, 0, 1);

        // start held high: accepts at k and k+2 only
        start = 1'b1;
        op = 3'b000;
        shamt = 3'd0;
        @(posedge clk);
        #1;
        e.dc = cyc + 1;
        e.y = 'h69;
        e.z = 0;
        e.c = 0;
        e.v = 0;
        q.push_back(e);
        e.dc = cyc + 3;
        q.push_back(e);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(1, "b2b_busy");
        repeat (6) @(posedge clk);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; power of two, >= 4.
REQ-002 SHALL have derived parameter SHW = $clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port load  in  1  operand load strobe.
REQ-006 SHALL have port sel_b  in  1  load target: 0 = operand A, 1 = operand B.
REQ-007 SHALL have port din  in  WIDTH  operand data.
REQ-008 SHALL have port start  in  1  operation request.
REQ-009 SHALL have port op  in  3  opcode.
REQ-010 SHALL have port shamt  in  SHW  shift amount.
REQ-011 SHALL have port y  out  WIDTH  registered result.
REQ-012 SHALL have ports zero, carry, overflow  out  1 each  registered flags.
REQ-013 SHALL have port busy  out  1  high while an operation executes.
REQ-014 SHALL have port done  out  1  one-cycle completion pulse.

Function
REQ-015 SHALL capture din into reg A (sel_b=0) or reg B (sel_b=1) at an edge where load=1 and busy=0; load while busy SHALL be ignored.
REQ-016 SHALL implement FSM states IDLE, EXEC, SHIFT, MUL; busy=1 in every state except IDLE.
REQ-017 SHALL, in IDLE with start=1, latch op and shamt and move to EXEC (op 000-100), SHIFT (101/110) or MUL (111); start while busy SHALL be ignored.
REQ-018 SHALL define opcodes: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 SHL A, 110 SHR A (logical), 111 MUL A*B.
REQ-019 SHALL complete EXEC in one cycle: y/flags updated and done=1 in the cycle after start is accepted, then IDLE.
REQ-020 SHALL shift one bit per cycle in SHIFT: done exactly max(shamt,1) cycles after start is accepted; shamt=0 yields y=A, carry=0.
REQ-021 SHALL set flags: zero = (y==0) for all ops; ADD carry = carry-out; SUB carry = no-borrow (A>=B); ADD/SUB overflow = signed overflow; shift carry = last bit shifted out; logic ops carry=overflow=0; shift overflow=0.
REQ-022 SHALL hold y and flags unchanged between done pulses; done SHALL be high for exactly one cycle per accepted start.
REQ-023 SHALL keep A and B unmodified by any operation; working copies SHALL be internal.
REQ-024 SHALL, with start held high continuously, accept a new operation only in the cycle after done (back-to-back, no skipped cycle).

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set A=B=0, y=0, zero=1, carry=0, overflow=0, busy=0, done=0, state IDLE.
REQ-026 SHALL, on reset during EXEC/SHIFT/MUL, abort the operation with no done pulse; rst SHALL take priority over load and start.

Configuration
REQ-027 SHALL use macro ALU_SEQ_MUL_EN: defined -> op 111 runs shift-add multiply in MUL for exactly WIDTH cycles, y = low WIDTH bits of product, overflow = (high WIDTH bits != 0), carry=0.
REQ-028 SHALL, without ALU_SEQ_MUL_EN, omit MUL state/logic; op 111 goes to EXEC, y=0, zero=1, carry=overflow=0, done after 1 cycle.

Verification (WIDTH=8)
REQ-029 SHALL cover: A=0x7F, B=0x01, ADD -> y=0x80, overflow=1, carry=0, zero=0, done 1 cycle after start.
REQ-030 SHALL cover: A=0x05, B=0x05, SUB -> y=0x00, zero=1, carry=1, overflow=0.
REQ-031 SHALL cover: A=0x81, SHL shamt=3 -> y=0x08, carry=0, busy high 3 cycles, done exactly 3 cycles after start.
REQ-032 SHALL cover: A=0x10, B=0x11, op 111 -> with ALU_SEQ_MUL_EN y=0x10, overflow=1, done after 8 cycles; without, y=0x00, zero=1, done after 1.
REQ-033 SHALL cover: SHR shamt=5 on A=0xF0, rst pulsed on 2nd SHIFT cycle -> busy=0, no done, y=0x00, zero=1 next cycle.
REQ-034 SHALL cover: start and load (din=0xAA) during a SHIFT -> both ignored, A/B unchanged, single done pulse.
